// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, divider step count and FSM states,
// plus the control-unit opcode that launches a divide.
package alu_pkg;

    localparam int DATA_W    = 32;
    localparam int DIV_STEPS = 32;

    localparam logic [5:0] OPC_DIV = 6'h1A;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FIXUP  = 2'd2,
        DONE   = 2'd3
    } div_state_t;

    function automatic logic [DATA_W-1:0] neg2c(input logic [DATA_W-1:0] v);
        return ~v + 1'b1;
    endfunction

    function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v);
        return v[DATA_W-1] ? neg2c(v) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {PR,Q} left, trial
// subtract the divisor and keep the result when it does not borrow.
module div_step
    import alu_pkg::*;
(
    input  logic [DATA_W:0]   pr_i,
    input  logic [DATA_W-1:0] q_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W:0]   pr_o,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W:0]   pr_sh;
    logic [DATA_W-1:0] q_sh;
    logic signed [DATA_W:0] trial;

    always_comb begin
        pr_sh = {pr_i[DATA_W-1:0], q_i[DATA_W-1]};
        q_sh  = {q_i[DATA_W-2:0], 1'b0};
        trial = $signed(pr_sh) - $signed({1'b0, d_i});
        // PR < D always holds, so trial fits in 33 bits and its MSB is the borrow.
        if (trial[DATA_W] == 1'b0) begin
            pr_o = trial;
            q_o  = q_sh | 1;
        end else begin
            pr_o = pr_sh;
            q_o  = q_sh;
        end
    end

endmodule

// File: rtl/divider_32_bit_seq.sv
// Sequential 32-bit restoring divider: one quotient bit per clock, 34-cycle latency.
// Define DIVIDER_SIGNED_EN for two's-complement signed operands (default: unsigned).
module divider_32_bit_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    div_state_t        state_q;
    logic [4:0]        cnt_q;
    logic [DATA_W:0]   pr_q, pr_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic [DATA_W-1:0] d_q;
    logic [DATA_W-1:0] quotient_q, remainder_q;
    logic              busy_q, done_q, dz_q;
`ifdef DIVIDER_SIGNED_EN
    logic              neg_q_q, neg_r_q;
`endif

    div_step u_step (
        .pr_i (pr_q),
        .q_i  (q_q),
        .d_i  (d_q),
        .pr_o (pr_d),
        .q_o  (q_d)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pr_q        <= '0;
            q_q         <= '0;
            d_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dz_q        <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (divisor == '0) begin
                            quotient_q  <= '1;
                            remainder_q <= dividend;
                            dz_q        <= 1'b1;
                            state_q     <= DONE;
                        end else begin
`ifdef DIVIDER_SIGNED_EN
                            q_q     <= mag(dividend);
                            d_q     <= mag(divisor);
                            neg_q_q <= dividend[DATA_W-1] ^ divisor[DATA_W-1];
                            neg_r_q <= dividend[DATA_W-1];
`else
                            q_q     <= dividend;
                            d_q     <= divisor;
`endif
                            pr_q    <= '0;
                            cnt_q   <= 5'(DIV_STEPS - 1);
                            dz_q    <= 1'b0;
                            state_q <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    pr_q <= pr_d;
                    q_q  <= q_d;
                    if (cnt_q == '0) begin
                        state_q <= FIXUP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                FIXUP: begin
                    // Quotient truncates toward zero; remainder follows the dividend sign.
`ifdef DIVIDER_SIGNED_EN
                    quotient_q  <= neg_q_q ? neg2c(q_q) : q_q;
                    remainder_q <= neg_r_q ? neg2c(pr_q[DATA_W-1:0]) : pr_q[DATA_W-1:0];
`else
                    quotient_q  <= q_q;
                    remainder_q <= pr_q[DATA_W-1:0];
`endif
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = dz_q;

endmodule

// File: doc/divider_32_bit_seq.md
# divider_32_bit_seq

Multi-cycle 32-bit integer divider in the ALU stage of the datapath. It sequences one shift-and-subtract step per clock (restoring algorithm) and returns quotient and remainder for the Z/HI:LO result registers. It sits alongside the combinational adder/subtractor, feeds the same result path, and is launched by the control unit's DIV micro-step.

## Interface
- `WIDTH`, 32: operand and result width. Only 32 is supported.
- `clk` input 1: clock. All state updates on the rising edge.
- `clr` input 1: asynchronous, active-high reset.
- `start` input 1: launch request. Sampled only in IDLE.
- `dividend` input 32: numerator. Sampled on the accepting edge.
- `divisor` input 32: denominator. Sampled on the accepting edge.
- `busy` output 1: high from the accepting edge until `done` is asserted.
- `done` output 1: single-cycle pulse; results are valid from this cycle on.
- `quotient` output 32: LO result.
- `remainder` output 32: HI result.
- `div_zero` output 1: divisor was zero for the last operation; held until the next accepted start.

## Operation
- States: IDLE, DIVIDE, FIXUP, DONE.
- IDLE:
  - `start`=1 and divisor≠0: latch |dividend| and |divisor| plus both sign bits, clear the 33-bit partial remainder, load count=31, go to DIVIDE, clear `div_zero`.
  - `start`=1 and divisor=0: go to DONE and load quotient=0xFFFF_FFFF, remainder=dividend, `div_zero`=1.
- DIVIDE, one step per cycle:
  - Shift {PR, Q} left by 1.
  - Compute trial = PR − D (33-bit).
  - If trial ≥ 0: PR=trial, Q[0]=1. Otherwise Q[0]=0.
  - At count=0, go to FIXUP; otherwise decrement count.
- FIXUP (signed build): negate Q if the sign bits differ; negate R if the dividend was negative. Quotient truncates toward zero; the remainder takes the dividend's sign. Write the results to the output registers and go to DONE.
- DONE: `done`=1 and `busy`=0 for one cycle, then return to IDLE.
- Outputs hold their values from DONE until the next operation's DONE. They do not change during DIVIDE.
- `start` asserted while not in IDLE is ignored. There is no queuing.
- Overflow case: −2^31 / −1 gives quotient 0x8000_0000 (two's-complement wrap) and remainder 0, with no flag.
- Arithmetic: magnitudes are 32-bit unsigned. The partial remainder is 33 bits so trial subtraction never loses the borrow. Negation is two's complement modulo 2^32.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_zero`=0. All internal registers are 0.
- Start accepted on edge k:
  - `busy` is high after edge k.
  - DIVIDE occupies edges k+1..k+32.
  - FIXUP is at edge k+33.
  - DONE is entered at edge k+34; `done` is high for the cycle following that edge.
- Latency: 34 cycles from start to `done`.
- Divide by zero: DONE is entered at edge k+1, so `done` follows 1 cycle after start.
- `start` may be asserted in the DONE cycle but is not accepted until IDLE, one cycle later. The minimum issue interval is 35 cycles.
- `clr` mid-operation:
  - Immediately forces the reset values; the operation in flight is discarded.
  - `done` never pulses for it.
  - The block accepts `start` on the first edge after `clr` deasserts.

## Configuration
- `DIVIDER_SIGNED_EN` defined: two's-complement signed division with sign handling as in FIXUP.
- `DIVIDER_SIGNED_EN` not defined:
  - Operands are treated as unsigned and sign latching is removed.
  - FIXUP only copies Q and R to the outputs; latency is unchanged.
  - Example: 0xFFFF_FFF0 / 2 = 0x7FFF_FFF8, remainder 0.

## Structure
- Shared package `alu_pkg` holds:
  - `DATA_W`=32.
  - `DIV_STEPS`=32.
  - State enum `div_state_t` {IDLE, DIVIDE, FIXUP, DONE}.
  - The opcode value for DIV, used by the control unit.
- Sub-module `div_step`: a purely combinational single iteration.
  - Inputs: PR[32:0], Q[31:0], D[31:0].
  - Outputs: next PR, next Q.
- The top level holds the FSM, counter, sign latches and output registers.

## Test plan
- 100 / 7 (signed): `done` 34 cycles after start; quotient=14, remainder=2, `div_zero`=0.
- −100 / 7: quotient=0xFFFF_FFF2 (−14), remainder=0xFFFF_FFFE (−2). Also 100 / −7 gives quotient −14, remainder 2.
- 5 / 0: `done` 1 cycle after start; quotient=0xFFFF_FFFF, remainder=5, `div_zero`=1. A following 9/3 clears `div_zero` and gives 3 r 0.
- 0x8000_0000 / 0xFFFF_FFFF: quotient=0x8000_0000, remainder=0.
- Start 1000/3, assert `start` again at cycle 5 with 8/2: second request ignored, result 333 r 1. Then pulse `clr` at cycle 10 of a new operation: all outputs 0, no `done` pulse, a fresh 8/2 afterwards gives 4 r 0.
- Unsigned build: 0xFFFF_FFF0 / 2 gives 0x7FFF_FFF8 r 0; 0xFFFF_FFFF / 0x10 gives 0x0FFF_FFFF r 0xF.
